// File: rtl/ps2_key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_fifo
// Description : PS/2 keyboard receiver. Synchronises and de-glitches the raw
//               PS/2 lines, deserialises 11-bit frames (start, 8 data LSB
//               first, odd parity, stop), folds E0/F0 prefixes into key
//               events and queues them in a first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_fifo #(
    parameter int DEPTH        = 16,
    parameter int FILT         = 4,
    parameter int TIMEOUT      = 50000,
    parameter int REPORT_BREAK = 1
) (
    input  logic                   clk,
    input  logic                   ar,
    input  logic                   ps2_clk,
    input  logic                   ps2_dat,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [9:0]             key_data,
    output logic                   key_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   rx_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_FW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILT - 1);
    localparam logic [c_TW-1:0] c_TMO       = c_TW'(TIMEOUT);
    localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(DEPTH);
    localparam logic            c_RB        = (REPORT_BREAK != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Input conditioning
    logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic              r_filt;
    logic [c_FW-1:0]   r_filt_cnt;
    logic              w_fall;

    // Frame receiver
    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par;
    logic [c_TW-1:0]   r_tmo;
    logic              w_tmo;
    logic              w_byte_good;
    logic              w_byte_bad;

    // Decoder
    logic              r_ext, r_brk;
    logic              r_evt_vld;
    logic [9:0]        r_evt;

    // FIFO
    logic [9:0]        r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              r_ovf, r_rx_err;
    logic              w_pop, w_push, w_drop, w_full;

    // Two-flop synchronisers; idle PS/2 lines are high
    always_ff @(posedge clk) begin
        if (!ar) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // A fall is the cycle in which the FILT-th consecutive low sample arrives
    assign w_fall = r_filt & ~r_clk_s2 & (r_filt_cnt == c_FILT_LAST);

    // Clock filter: level follows the synchronised clock after FILT equal samples
    always_ff @(posedge clk) begin
        if (!ar) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 != r_filt) begin
            if (r_filt_cnt == c_FILT_LAST) begin
                r_filt     <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end else begin
            r_filt_cnt <= '0;
        end
    end

    // A real fall takes precedence over an expiring idle timer
    assign w_tmo       = (r_state != S_IDLE) && !w_fall && (r_tmo == c_TMO);
    assign w_byte_good = w_fall && (r_state == S_STOP) && (^{r_shift, r_par}) && r_dat_s2;
    assign w_byte_bad  = w_fall && (r_state == S_STOP) && !((^{r_shift, r_par}) && r_dat_s2);

    // Frame FSM with idle timer that abandons stalled partial frames
    always_ff @(posedge clk) begin
        if (!ar) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tmo     <= '0;
        end else begin
            if (r_state == S_IDLE || w_fall) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_tmo) begin
                r_state <= S_IDLE;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= S_STOP;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Prefix decoder: E0/F0 set flags, any other byte emits one event
    always_ff @(posedge clk) begin
        if (!ar) begin
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_evt_vld <= 1'b0;
            r_evt     <= '0;
        end else begin
            r_evt_vld <= 1'b0;
            if (w_tmo) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_good) begin
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_evt     <= {r_ext, r_brk, r_shift};
                    r_evt_vld <= !r_brk || c_RB;
                    r_ext     <= 1'b0;
                    r_brk     <= 1'b0;
                end
            end
        end
    end

    // When full, a simultaneous pop frees the slot so the push still lands
    assign w_full = (r_count == c_DEPTH);
    assign w_pop  = rd_en && (r_count != '0);
    assign w_push = r_evt_vld && (!w_full || w_pop);
    assign w_drop = r_evt_vld && w_full && !w_pop;

    // Event storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_evt;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!ar) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle wins
    always_ff @(posedge clk) begin
        if (!ar) begin
            r_ovf    <= 1'b0;
            r_rx_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (w_byte_bad) begin
                r_rx_err <= 1'b1;
            end else if (clr_err) begin
                r_rx_err <= 1'b0;
            end
        end
    end

    assign key_valid  = (r_count != '0);
    assign key_data   = key_valid ? r_mem[r_rd_ptr] : 10'd0;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
    assign rx_err     = r_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_fifo
// Description : Self-checking bench for ps2_key_fifo. A queue-based model of
//               key events is updated from the bytes sent on the PS/2 lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_fifo;

    localparam int DEPTH   = 16;
    localparam int FILT    = 4;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 12;

    logic       clk = 1'b0;
    logic       ar = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rd_en = 1'b0;
    logic       rd_en2 = 1'b0;
    logic       clr_err = 1'b0;
    logic [9:0] key_data, key_data2;
    logic       key_valid, key_valid2;
    logic [4:0] fifo_count, fifo_count2;
    logic       overflow, overflow2, rx_err, rx_err2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued events for both variants, prefix flags, sticky errors
    logic [9:0] mq[$];
    logic [9:0] mq2[$];
    bit m_ext, m_brk, m_ovf, m_err;

    ps2_key_fifo #(.DEPTH(DEPTH), .FILT(FILT), .TIMEOUT(TIMEOUT), .REPORT_BREAK(1)) dut (
        .clk(clk), .ar(ar), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .rd_en(rd_en),
        .clr_err(clr_err), .key_data(key_data), .key_valid(key_valid),
        .fifo_count(fifo_count), .overflow(overflow), .rx_err(rx_err)
    );

    ps2_key_fifo #(.DEPTH(DEPTH), .FILT(FILT), .TIMEOUT(TIMEOUT), .REPORT_BREAK(0)) dut2 (
        .clk(clk), .ar(ar), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .rd_en(rd_en2),
        .clr_err(clr_err), .key_data(key_data2), .key_valid(key_valid2),
        .fifo_count(fifo_count2), .overflow(overflow2), .rx_err(rx_err2)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang, need finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        mq.delete();
        mq2.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic [9:0] ev;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            ev = {m_ext, m_brk, b};
            if (mq.size() < DEPTH) mq.push_back(ev);
            else m_ovf = 1;
            if (!m_brk && mq2.size() < DEPTH) mq2.push_back(ev);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic do_reset();
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        ar = 1'b0;
        idle(3);
        ar = 1'b1;
        idle(2);
        m_reset();
    endtask

    // Drive n bits (LSB first); optionally pop exactly when the stop-bit event is written
    task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_stop);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            idle(HALF);
            ps2_clk = 1'b0;
            if (pop_stop && i == 10) begin
                idle(6);
                rd_en = 1'b1;
                idle(1);
                rd_en = 1'b0;
                idle(HALF - 7);
            end else begin
                idle(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_stop);
        logic par;
        par = (~^b) ^ bad_par;
        send_bits({1'b1, par, b, 1'b0}, 11, pop_stop);
        idle(10);
        if (bad_par) m_err = 1;
        else m_byte(b);
    endtask

    task automatic test_reset();
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 1, 0);
        send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5, 0);
        ar = 1'b0;
        idle(2);
        n_tests++; if (key_data !== 10'd0) begin n_fail++; $display("FAIL reset_key_data got %h need 000", key_data); end
        n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid got %b need 0", key_valid); end
        n_tests++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d need 0", fifo_count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b need 0", overflow); end
        n_tests++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_rx_err got %b need 0", rx_err); end
        ar = 1'b1;
        idle(2);
        m_reset();
        send_frame(8'h1C, 0, 0);
        n_tests++; if (fifo_count !== 5'(mq.size()) || key_data !== mq[0]) begin
            n_fail++; $display("FAIL reset_next_frame got cnt=%0d data=%h need cnt=%0d data=%h", fifo_count, key_data, mq.size(), mq[0]);
        end
    endtask

    task automatic test_make();
        do_reset();
        send_frame(8'h1C, 0, 0);
        n_tests++; if (key_valid !== 1'b1 || fifo_count !== 5'd1) begin
            n_fail++; $display("FAIL make_valid got v=%b cnt=%0d need v=1 cnt=1", key_valid, fifo_count);
        end
        n_tests++; if (key_data !== mq[0]) begin n_fail++; $display("FAIL make_data got %h need %h", key_data, mq[0]); end
        rd_en = 1'b1; idle(1); rd_en = 1'b0;
        void'(mq.pop_front());
        n_tests++; if (key_valid !== 1'b0 || fifo_count !== 5'(mq.size())) begin
            n_fail++; $display("FAIL make_pop got v=%b cnt=%0d need v=0 cnt=0", key_valid, fifo_count);
        end
    endtask

    task automatic test_break_ext();
        do_reset();
        send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
        send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
        n_tests++; if (fifo_count !== 5'(mq.size())) begin n_fail++; $display("FAIL brk_count got %0d need %0d", fifo_count, mq.size()); end
        for (int k = 0; k < DEPTH && mq.size() > 0; k++) begin
            n_tests++; if (key_data !== mq[0]) begin n_fail++; $display("FAIL brk_head%0d got %h need %h", k, key_data, mq[0]); end
            rd_en = 1'b1; idle(1); rd_en = 1'b0;
            void'(mq.pop_front());
        end
        n_tests++; if (fifo_count2 !== 5'(mq2.size())) begin n_fail++; $display("FAIL nobrk_count got %0d need %0d", fifo_count2, mq2.size()); end
        for (int k = 0; k < DEPTH && mq2.size() > 0; k++) begin
            n_tests++; if (key_data2 !== mq2[0]) begin n_fail++; $display("FAIL nobrk_head%0d got %h need %h", k, key_data2, mq2[0]); end
            rd_en2 = 1'b1; idle(1); rd_en2 = 1'b0;
            void'(mq2.pop_front());
        end
        n_tests++; if (key_valid2 !== 1'b0) begin n_fail++; $display("FAIL nobrk_empty got v=%b need 0", key_valid2); end
    endtask

    task automatic test_parity();
        do_reset();
        send_frame(8'h1C, 1, 0);
        n_tests++; if (fifo_count !== 5'd0 || rx_err !== 1'b1) begin
            n_fail++; $display("FAIL parity_err got cnt=%0d err=%b need cnt=0 err=1", fifo_count, rx_err);
        end
        clr_err = 1'b1; idle(1); clr_err = 1'b0;
        m_err = 0;
        n_tests++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL parity_clr got %b need 0", rx_err); end
        send_frame(8'h1C, 0, 0);
        n_tests++; if (fifo_count !== 5'd1 || key_data !== mq[0]) begin
            n_fail++; $display("FAIL parity_recover got cnt=%0d data=%h need cnt=1 data=%h", fifo_count, key_data, mq[0]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 1; c <= DEPTH + 1; c++) send_frame(8'(c), 0, 0);
        n_tests++; if (fifo_count !== 5'd16 || overflow !== m_ovf) begin
            n_fail++; $display("FAIL ovf_state got cnt=%0d ovf=%b need cnt=16 ovf=%b", fifo_count, overflow, m_ovf);
        end
        for (int k = 0; k < DEPTH + 2 && mq.size() > 0; k++) begin
            n_tests++; if (key_data !== mq[0]) begin n_fail++; $display("FAIL ovf_head%0d got %h need %h", k, key_data, mq[0]); end
            rd_en = 1'b1; idle(1); rd_en = 1'b0;
            void'(mq.pop_front());
        end
        n_tests++; if (key_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drained got v=%b ovf=%b need v=0 ovf=1", key_valid, overflow);
        end
        clr_err = 1'b1; idle(1); clr_err = 1'b0;
        m_ovf = 0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b need 0", overflow); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_bits({1'b1, 1'b0, 8'hAA, 1'b0}, 5, 0);
        idle(TIMEOUT + 10);
        m_ext = 0; m_brk = 0;
        send_frame(8'h1C, 0, 0);
        n_tests++; if (fifo_count !== 5'd1 || key_data !== mq[0] || rx_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout got cnt=%0d data=%h err=%b need cnt=1 data=%h err=0", fifo_count, key_data, rx_err, mq[0]);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int c = 0; c < DEPTH; c++) send_frame(8'(8'h21 + c), 0, 0);
        n_tests++; if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_pre got cnt=%0d ovf=%b need cnt=16 ovf=0", fifo_count, overflow);
        end
        void'(mq.pop_front());
        send_frame(8'h31, 0, 1);
        n_tests++; if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_pushpop got cnt=%0d ovf=%b need cnt=16 ovf=0", fifo_count, overflow);
        end
        for (int k = 0; k < DEPTH + 2 && mq.size() > 0; k++) begin
            n_tests++; if (key_data !== mq[0]) begin n_fail++; $display("FAIL full_head%0d got %h need %h", k, key_data, mq[0]); end
            rd_en = 1'b1; idle(1); rd_en = 1'b0;
            void'(mq.pop_front());
        end
    endtask

    task automatic test_glitch();
        do_reset();
        ps2_dat = 1'b0;
        idle(5);
        ps2_clk = 1'b0;
        idle(FILT - 1);
        ps2_clk = 1'b1;
        idle(10);
        ps2_dat = 1'b1;
        idle(10);
        send_frame(8'h1C, 0, 0);
        n_tests++; if (fifo_count !== 5'd1 || key_data !== mq[0] || rx_err !== 1'b0) begin
            n_fail++; $display("FAIL glitch got cnt=%0d data=%h err=%b need cnt=1 data=%h err=0", fifo_count, key_data, rx_err, mq[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         r;
        do_reset();
        for (int round = 0; round < 4; round++) begin
            for (int f = 0; f < 10; f++) begin
                r = $urandom_range(0, 9);
                if (r == 0) b = 8'hE0;
                else if (r == 1) b = 8'hF0;
                else begin
                    b = 8'($urandom_range(0, 255));
                    while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom_range(0, 255));
                end
                send_frame(b, (r == 9), 0);
            end
            n_tests++; if (fifo_count !== 5'(mq.size()) || rx_err !== m_err) begin
                n_fail++; $display("FAIL rand%0d_state got cnt=%0d err=%b need cnt=%0d err=%b", round, fifo_count, rx_err, mq.size(), m_err);
            end
            for (int k = 0; k < DEPTH + 2 && mq.size() > 0; k++) begin
                n_tests++; if (key_data !== mq[0]) begin n_fail++; $display("FAIL rand%0d_head%0d got %h need %h", round, k, key_data, mq[0]); end
                rd_en = 1'b1; idle(1); rd_en = 1'b0;
                void'(mq.pop_front());
            end
            n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rand%0d_empty got v=%b need 0", round, key_valid); end
            clr_err = 1'b1; idle(1); clr_err = 1'b0;
            m_err = 0;
        end
    endtask

    initial begin
        m_reset();
        idle(4);
        ar = 1'b1;
        idle(2);
        test_reset();
        test_make();
        test_break_ext();
        test_parity();
        test_overflow();
        test_timeout();
        test_full_push_pop();
        test_glitch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
